// File: rtl/mult_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_arb_pkg
// Description : Shared types and helpers for the arbitrated sequential
//               multiplier (FSM state type, default sizes, sign extension).
// Revision    : 1.0 - initial release
// ============================================================================
package mult_arb_pkg;

    localparam int c_n_default = 8;
    localparam int c_r_default = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Replicates bit w-1 of v into every bit at or above w.
    function automatic logic [63:0] sext(input logic [63:0] v, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            r[i] = (i < w) ? v[i] : v[w-1];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter_if
// Description : Request/response bundle between R requesters and the shared
//               multiplier. master = requester side, slave = arbiter side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int N = c_n_default,
    parameter int R = c_r_default
);
    localparam int c_id_w = (R > 1) ? $clog2(R) : 1;

    logic [R-1:0]      req_valid;
    logic [R-1:0]      req_ready;
    logic [R*N-1:0]    req_a;
    logic [R*N-1:0]    req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [c_id_w-1:0] rsp_id;
    logic [2*N-1:0]    rsp_c;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_c
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_c
    );

endinterface
`default_nettype wire

// File: rtl/mult_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : mult_seq_core
// Description : Signed shift-add multiplier, one multiplicand bit per cycle.
//               Optional macro MULT_EARLY_OUT_EN ends the run once the
//               remaining multiplicand bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_core
    import mult_arb_pkg::*;
#(
    parameter int N = c_n_default
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           start,
    input  wire logic [N-1:0]   a,
    input  wire logic [N-1:0]   b,
    output logic                done,
    output logic [2*N-1:0]      product
);
    localparam int c_w2    = 2 * N;
    localparam int c_cnt_w = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]       r_aa;
    logic [c_w2-1:0]    r_bb;
    logic [c_w2-1:0]    r_acc;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_active;

    logic [c_w2-1:0]    w_bsx;
    logic [c_w2-1:0]    w_bb_init;
    logic [N-1:0]       w_aa_init;
    logic [N-1:0]       w_aa_next;
    logic [c_w2-1:0]    w_acc_next;
    logic               w_last;

    // A negative multiplicand is folded into b so aa is always a magnitude;
    // the N-bit negate of -2^(N-1) yields 2^(N-1) as needed.
    assign w_bsx      = c_w2'(sext(64'(b), N));
    assign w_aa_init  = a[N-1] ? (~a + N'(1)) : a;
    assign w_bb_init  = a[N-1] ? (~w_bsx + c_w2'(1)) : w_bsx;

    assign w_aa_next  = r_aa >> 1;
    assign w_acc_next = r_aa[0] ? (r_acc + r_bb) : r_acc;

`ifdef MULT_EARLY_OUT_EN
    assign w_last = (r_cnt == c_cnt_w'(N - 1)) || (w_aa_next == '0);
`else
    assign w_last = (r_cnt == c_cnt_w'(N - 1));
`endif

    assign done    = r_active && w_last;
    assign product = w_acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aa     <= '0;
            r_bb     <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_aa     <= w_aa_init;
            r_bb     <= w_bb_init;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_aa     <= w_aa_next;
            r_bb     <= r_bb << 1;
            r_acc    <= w_acc_next;
            r_cnt    <= r_cnt + c_cnt_w'(1);
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin sharing of one mult_seq_core between R requesters
//               with a tagged, registered response channel. Latency shortens
//               when MULT_EARLY_OUT_EN is defined (see mult_seq_core).
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N = c_n_default,
    parameter int R = c_r_default
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mult_arbiter_if.slave bus,
    output logic          busy
);
    localparam int c_id_w = (R > 1) ? $clog2(R) : 1;

    state_t             r_state;
    logic [c_id_w-1:0]  r_rr_ptr;
    logic [c_id_w-1:0]  r_id;
    logic               r_rsp_valid;
    logic [2*N-1:0]     r_rsp_c;

    logic               w_any;
    logic [c_id_w-1:0]  w_grant;
    logic [N-1:0]       w_a;
    logic [N-1:0]       w_b;
    logic               w_start;
    logic               w_done;
    logic [2*N-1:0]     w_product;

    // First valid requester at or after r_rr_ptr, wrapping modulo R.
    always_comb begin : p_arb
        int j;
        j       = 0;
        w_any   = 1'b0;
        w_grant = '0;
        w_a     = '0;
        w_b     = '0;
        for (int k = 0; k < R; k++) begin
            j = int'(r_rr_ptr) + k;
            if (j >= R) begin
                j = j - R;
            end
            if (!w_any && bus.req_valid[j]) begin
                w_any   = 1'b1;
                w_grant = c_id_w'(j);
                w_a     = bus.req_a[j*N +: N];
                w_b     = bus.req_b[j*N +: N];
            end
        end
    end

    assign w_start       = (r_state == ST_IDLE) && w_any && !rst;
    assign bus.req_ready = w_start ? (R'(1) << w_grant) : '0;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_c     = r_rsp_c;
    assign bus.rsp_id    = r_id;
    assign busy          = (r_state != ST_IDLE);

    mult_seq_core #(
        .N       (N)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .a       (w_a),
        .b       (w_b),
        .done    (w_done),
        .product (w_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_c     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_id    <= w_grant;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_done) begin
                        r_rsp_c     <= w_product;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (r_rsp_valid && bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rr_ptr    <= (int'(r_id) == R - 1) ? '0 : r_id + c_id_w'(1);
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Directed self-checking bench for mult_arbiter (N=8, R=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;
    import mult_arb_pkg::*;

`ifdef MULT_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    mult_arbiter_if #(.N(8), .R(4)) bus ();

    mult_arbiter #(.N(8), .R(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated request: grant in cycle T, response counted from T.
    task automatic run_one(input string tag, input int idx, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] exp_c, input int exp_lat);
        int lat;
        bus.req_a[idx*8 +: 8] = a;
        bus.req_b[idx*8 +: 8] = b;
        bus.req_valid = 4'b0001 << idx;
        bus.rsp_ready = 1'b1;
        #1;
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'(4'b0001 << idx));
        step();
        bus.req_valid = 4'b0000;
        lat = 1;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_c"}, 32'(bus.rsp_c), 32'(exp_c));
        chk({tag, "_id"}, 32'(bus.rsp_id), 32'(idx));
        step();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    int          rr_ids[5]  = '{0, 1, 2, 3, 0};
    int          sp_eo[4]   = '{4, 5, 5, 3};
    logic [15:0] rr_c[4]    = '{16'h0006, 16'hFFEC, 16'hFFCF, 16'h0001};

    initial begin
        int n;
        int prev;
        bus.req_valid = 4'b0001;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_c", 32'(bus.rsp_c), 32'd0);
        chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
        bus.req_valid = 4'b0000;
        rst = 1'b0;
        step();

        run_one("p3x5",     0, 8'd3,   8'd5,   16'h000F, EO ? 3 : 9);
        run_one("m3x7",     1, 8'hFD,  8'd7,   16'hFFEB, EO ? 3 : 9);
        run_one("p5xm128",  2, 8'd5,   8'h80,  16'hFD80, EO ? 4 : 9);
        run_one("m128sq",   3, 8'h80,  8'h80,  16'h4000, 9);
        run_one("zxm1",     0, 8'd0,   8'hFF,  16'h0000, EO ? 2 : 9);
        run_one("p1x9",     1, 8'd1,   8'd9,   16'h0009, EO ? 2 : 9);
        run_one("p64x1",    2, 8'h40,  8'd1,   16'h0040, EO ? 8 : 9);
        run_one("m1x127",   3, 8'hFF,  8'h7F,  16'hFF81, EO ? 2 : 9);

        // All four requesting at once; pointer is back at 0 here.
        bus.req_a = {8'hFF, 8'd7, 8'hFC, 8'd2};
        bus.req_b = {8'hFF, 8'hF9, 8'd5, 8'd3};
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        #1;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (bus.req_ready === 4'b0000 && n < 40) begin
                step();
                n++;
            end
            chk("rr_grant", 32'(bus.req_ready), 32'(4'b0001 << rr_ids[k]));
            if (k > 0) chk("rr_spacing", 32'(cyc - prev), 32'(EO ? sp_eo[k-1] : 10));
            prev = cyc;
            step();
            n = 0;
            while (bus.rsp_valid !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            chk("rr_rsp_id", 32'(bus.rsp_id), 32'(rr_ids[k]));
            chk("rr_rsp_c", 32'(bus.rsp_c), 32'(rr_c[rr_ids[k]]));
            step();
        end
        bus.req_valid = 4'b0000;
        step();

        // Back-pressure on the response channel.
        bus.req_a[15:8] = 8'd6;
        bus.req_b[15:8] = 8'hFE;
        bus.req_valid   = 4'b0010;
        bus.rsp_ready   = 1'b0;
        #1;
        chk("stall_grant", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_a[23:16] = 8'h11;
        bus.req_b[23:16] = 8'h02;
        bus.req_valid    = 4'b0100;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("stall_wait", 32'(n < 40), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
            chk("stall_c", 32'(bus.rsp_c), 32'hFFF4);
            chk("stall_id", 32'(bus.rsp_id), 32'd1);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("stall_hold_last", 32'(bus.rsp_valid), 32'd1);
        step();
        chk("stall_done_valid", 32'(bus.rsp_valid), 32'd0);
        chk("stall_done_busy", 32'(busy), 32'd0);
        chk("stall_next_grant", 32'(bus.req_ready), 32'h4);

        // Accept requester 2, then abort it with a reset mid-run.
        step();
        bus.req_valid = 4'b0110;
        step();
        step();
        chk("abort_running", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("abort_regrant", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = 4'b0000;
        n = 1;
        while (bus.rsp_valid !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("abort_next_latency", 32'(n), 32'(EO ? 4 : 9));
        chk("abort_next_id", 32'(bus.rsp_id), 32'd1);
        chk("abort_next_c", 32'(bus.rsp_c), 32'hFFF4);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one sequential signed shift-add multiplier engine between R requesters. Each requester presents an operand pair on a valid/ready handshake. A round-robin arbiter grants one requester at a time, and the block sequences the engine. Each result is returned on a single response channel, tagged with the requester index.

## Interface
Parameters:
- N, 8: operand width (two's complement)
- R, 4: number of requesters (≥2)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  R  per-requester request valid
- req_ready  out  R  per-requester grant/accept; at most one bit set
- req_a  in  R*N  multiplicand per requester; slice i = bits [i*N +: N]
- req_b  in  R*N  multiplier operand per requester, same slicing
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  $clog2(R)  index of the requester that owns rsp_c
- rsp_c  out  2N  signed product, two's complement
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, RUN, RESP.
- IDLE:
  - If any req_valid is high, pick the first set bit at or after rr_ptr, wrapping modulo R.
  - Drive req_ready for that one index, combinationally, in the same cycle.
  - Latch its a/b and its index, then go to RUN.
  - If no req_valid is high, stay in IDLE with req_ready = 0.
- req_ready is 0 in RUN and RESP.
- Requesters must hold valid and operands stable until accepted.
- Operand preparation at accept:
  - If a is negative: aa = −a (as N-bit unsigned magnitude; −2^(N−1) gives 2^(N−1)), and bb = −sext(b) in 2N bits.
  - Otherwise: aa = a, and bb = sext(b).
  - acc = 0, cnt = 0.
- RUN, every cycle:
  - If aa[0], then acc += bb (mod 2^2N).
  - aa >>= 1, bb <<= 1, cnt++.
  - Exit to RESP after the cycle in which cnt == N−1. The early-out exit is defined under Configuration.
- RESP:
  - rsp_valid = 1, with rsp_c = acc and rsp_id = latched index, all held stable until rsp_ready.
  - On rsp_valid && rsp_ready: go to IDLE, and set rr_ptr = (granted index + 1) mod R.
- Result equals a*b exactly for all operand pairs, including (−2^(N−1))².
- Reset:
  - State ← IDLE, rr_ptr ← 0, and acc/aa/bb/cnt ← 0.
  - Outputs: rsp_valid 0, rsp_c 0, rsp_id 0, req_ready 0, busy 0.
  - Reset mid-RUN or mid-RESP discards the in-flight product. No response is produced for it.

## Timing
- Accept handshake occurs in cycle T. RUN spans cycles T+1 … T+N.
- rsp_valid first high in cycle T+N+1, so fixed latency is N+1 cycles.
- If rsp_ready is already high in that cycle, the response completes in T+N+1 and the state is IDLE in T+N+2.
- The earliest next accept is cycle T+N+2. This one-cycle bubble after RESP is intended.
- rsp_valid is registered. req_ready is combinational from req_valid, rr_ptr and state.
- Simultaneous requests are served strictly round-robin. No requester waits more than R−1 other grants.
- rsp_ready while rsp_valid is 0 is ignored.

## Configuration
- MULT_EARLY_OUT_EN:
  - When defined, RUN also exits after the cycle in which the shifted aa becomes 0.
  - RUN length is then max(1, bit index of aa's MSB + 1) cycles. a = 0 or a = ±1 gives 1 RUN cycle.
  - When undefined, RUN is always exactly N cycles.
- Results are identical in both builds. Only latency differs.

## Structure
- Package mult_arb_pkg holds:
  - the state enum type (IDLE, RUN, RESP);
  - the default N and R constants;
  - a sext helper function.
- Sub-module mult_seq_core holds aa/bb/acc/cnt and the exit condition.
  - Interface: start (with a, b), done pulse, product.
  - mult_arbiter holds the FSM, the round-robin arbiter and the response registers.
  - mult_arbiter instantiates one mult_seq_core.

## Test plan
All scenarios use N=8, R=4, with MULT_EARLY_OUT_EN undefined unless stated.
- req_valid = 0001, a=3, b=5, rsp_ready=1:
  - req_ready[0] is high in the request cycle T.
  - rsp_valid is high in T+9 with rsp_c=0x000F and rsp_id=0.
- Signed cases, one at a time:
  - a=−3, b=7 → rsp_c 0xFFEB.
  - a=5, b=−128 → 0xFD80.
  - a=−128, b=−128 → 0x4000.
  - a=0, b=−1 → 0x0000.
- req_valid = 1111 held continuously, with distinct operands per requester:
  - Grants occur in order 0, 1, 2, 3, 0.
  - Each rsp_id matches its owner's product, with 10-cycle spacing between accepts.
- rsp_ready held low for 5 cycles after rsp_valid rises:
  - rsp_c and rsp_id stay stable, req_ready stays 0 and busy stays 1.
  - The handshake completes on the cycle rsp_ready rises.
- rst pulsed for 1 cycle mid-RUN:
  - Next cycle: busy 0 and rsp_valid 0; no response is produced for the aborted request.
  - A pending req_valid=0010 is then granted, since rr_ptr is 0.
- MULT_EARLY_OUT_EN defined, a=1, b=9:
  - rsp_valid is high in T+2 with rsp_c=0x0009.
  - a=0x40 gives rsp_valid in T+8.
